// File: rtl/pipeline_hazard_controller.sv
// Decode-stage hazard scoreboard: stall, forwarding selects, MDU busy.
// Optional MDU tracking enabled by defining PIPELINE_HAZARD_MDU_EN.
module pipeline_hazard_controller #(
  parameter  int DEPTH      = 3,
  parameter  int REG_ADDR_W = 5,
  parameter  int MUL_CYCLES = 5,
  parameter  int DIV_CYCLES = 10,
  localparam int SEL_W      = $clog2(DEPTH + 1),
  localparam int CNT_W      = $clog2(DIV_CYCLES + 1)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  freeze,
  input  logic                  dec_valid,
  input  logic [REG_ADDR_W-1:0] dec_rs_id,
  input  logic [REG_ADDR_W-1:0] dec_rt_id,
  input  logic [1:0]            dec_rs_stage,
  input  logic [1:0]            dec_rt_stage,
  input  logic                  dec_wr_en,
  input  logic [REG_ADDR_W-1:0] dec_wr_id,
  input  logic [1:0]            dec_wr_ready,
  input  logic                  dec_mdu_use,
  input  logic                  dec_mdu_start,
  input  logic                  dec_mdu_div,
  output logic                  stall,
  output logic [SEL_W-1:0]      fwd_rs_sel,
  output logic [SEL_W-1:0]      fwd_rt_sel,
  output logic                  mdu_busy
);

  typedef struct packed {
    logic                  vld;
    logic [REG_ADDR_W-1:0] id;
    logic [1:0]            rdy;
  } ent_t;

  ent_t ent [DEPTH];
  ent_t ent_in;

  logic [REG_ADDR_W-1:0] src_id  [2];
  logic [1:0]            src_stg [2];
  logic [SEL_W-1:0]      src_sel [2];
  logic [1:0]            src_hz;
  logic                  mdu_hz;

  assign src_id[0]  = dec_rs_id;
  assign src_id[1]  = dec_rt_id;
  assign src_stg[0] = dec_rs_stage;
  assign src_stg[1] = dec_rt_stage;

  // Oldest-to-youngest scan so the youngest match wins.
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      src_sel[s] = '0;
      src_hz[s]  = 1'b0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (ent[k].vld &&
            ent[k].id == src_id[s] &&
            src_id[s] != '0 &&
            src_stg[s] != 2'd3) begin
          src_sel[s] = SEL_W'(k + 1);
          src_hz[s]  = (k + 1 + int'(src_stg[s]))
                       <= int'(ent[k].rdy);
        end
      end
    end
  end

  assign fwd_rs_sel = src_sel[0];
  assign fwd_rt_sel = src_sel[1];

  assign stall = dec_valid &
                 (src_hz[0] | src_hz[1] | mdu_hz);

  always_comb begin
    ent_in     = '0;
    ent_in.vld = dec_valid & dec_wr_en & ~stall &
                 (dec_wr_id != '0);
    ent_in.id  = dec_wr_id;
    ent_in.rdy = dec_wr_ready;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < DEPTH; k++)
        ent[k] <= '0;
    end else if (!freeze) begin
      ent[0] <= ent_in;
      for (int k = 1; k < DEPTH; k++)
        ent[k] <= ent[k-1];
    end
  end

`ifdef PIPELINE_HAZARD_MDU_EN
  logic [CNT_W-1:0] mdu_cnt;
  logic             mdu_go;

  assign mdu_go = dec_valid & dec_mdu_start &
                  ~stall & ~freeze;

  // Counter keeps running through freeze.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      mdu_cnt <= '0;
    else if (mdu_go)
      mdu_cnt <= dec_mdu_div ? CNT_W'(DIV_CYCLES)
                             : CNT_W'(MUL_CYCLES);
    else if (mdu_cnt != '0)
      mdu_cnt <= mdu_cnt - CNT_W'(1);
  end

  assign mdu_busy = (mdu_cnt != '0);
  assign mdu_hz   = mdu_busy &
                    (dec_mdu_use | dec_mdu_start);
`else
  logic unused_mdu;
  assign unused_mdu = ^{dec_mdu_use, dec_mdu_start,
                        dec_mdu_div,
                        CNT_W'(MUL_CYCLES),
                        CNT_W'(DIV_CYCLES)};
  assign mdu_busy = 1'b0;
  assign mdu_hz   = 1'b0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Scoreboard bench for pipeline_hazard_controller (default params).
// Expectations depend on PIPELINE_HAZARD_MDU_EN.
module tb_pipeline_hazard_controller;

`ifdef PIPELINE_HAZARD_MDU_EN
  localparam bit MDU = 1'b1;
`else
  localparam bit MDU = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       freeze = 1'b0;
  logic       dec_valid = 1'b0;
  logic [4:0] dec_rs_id = '0;
  logic [4:0] dec_rt_id = '0;
  logic [1:0] dec_rs_stage = 2'd3;
  logic [1:0] dec_rt_stage = 2'd3;
  logic       dec_wr_en = 1'b0;
  logic [4:0] dec_wr_id = '0;
  logic [1:0] dec_wr_ready = '0;
  logic       dec_mdu_use = 1'b0;
  logic       dec_mdu_start = 1'b0;
  logic       dec_mdu_div = 1'b0;
  logic       stall;
  logic [1:0] fwd_rs_sel;
  logic [1:0] fwd_rt_sel;
  logic       mdu_busy;

  pipeline_hazard_controller dut (
    .clock(clock),
    .reset_n(reset_n),
    .freeze(freeze),
    .dec_valid(dec_valid),
    .dec_rs_id(dec_rs_id),
    .dec_rt_id(dec_rt_id),
    .dec_rs_stage(dec_rs_stage),
    .dec_rt_stage(dec_rt_stage),
    .dec_wr_en(dec_wr_en),
    .dec_wr_id(dec_wr_id),
    .dec_wr_ready(dec_wr_ready),
    .dec_mdu_use(dec_mdu_use),
    .dec_mdu_start(dec_mdu_start),
    .dec_mdu_div(dec_mdu_div),
    .stall(stall),
    .fwd_rs_sel(fwd_rs_sel),
    .fwd_rt_sel(fwd_rt_sel),
    .mdu_busy(mdu_busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       rst_n;
    logic       frz;
    logic       v;
    logic [4:0] rs;
    logic [1:0] rss;
    logic [4:0] rt;
    logic [1:0] rts;
    logic       we;
    logic [4:0] wd;
    logic [1:0] wr;
    logic       mu;
    logic       ms;
    logic       md;
  } stim_t;

  typedef struct {
    string name;
    int    stall;
    int    rs;
    int    rt;
    int    busy;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;

  function automatic void chk(string nm, string f,
                              int got, int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s %s got=%0d want=%0d",
               nm, f, got, want);
    end
  endfunction

  function automatic stim_t ins(int rs, int rss,
                                int rt, int rts,
                                int wd, int wr);
    stim_t s;
    s.rst_n = 1'b1;
    s.frz   = 1'b0;
    s.v     = 1'b1;
    s.rs    = 5'(rs);
    s.rss   = 2'(rss);
    s.rt    = 5'(rt);
    s.rts   = 2'(rts);
    s.we    = (wd >= 0);
    s.wd    = (wd >= 0) ? 5'(wd) : 5'd0;
    s.wr    = 2'(wr);
    s.mu    = 1'b0;
    s.ms    = 1'b0;
    s.md    = 1'b0;
    return s;
  endfunction

  task automatic step(stim_t s, string nm,
                      int es, int ers, int ert, int eb);
    exp_t e;
    @(negedge clock);
    reset_n       = s.rst_n;
    freeze        = s.frz;
    dec_valid     = s.v;
    dec_rs_id     = s.rs;
    dec_rs_stage  = s.rss;
    dec_rt_id     = s.rt;
    dec_rt_stage  = s.rts;
    dec_wr_en     = s.we;
    dec_wr_id     = s.wd;
    dec_wr_ready  = s.wr;
    dec_mdu_use   = s.mu;
    dec_mdu_start = s.ms;
    dec_mdu_div   = s.md;
    e.name  = nm;
    e.stall = es;
    e.rs    = ers;
    e.rt    = ert;
    e.busy  = eb;
    sb.push_back(e);
  endtask

  // Monitor: sample just before the rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      #3;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk(e.name, "stall", int'(stall), e.stall);
        chk(e.name, "rs_sel", int'(fwd_rs_sel), e.rs);
        chk(e.name, "rt_sel", int'(fwd_rt_sel), e.rt);
        chk(e.name, "busy", int'(mdu_busy), e.busy);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    stim_t s;
    int m;
    m = MDU ? 1 : 0;

    s = ins(8, 0, 0, 3, -1, 0);
    s.rst_n = 1'b0;
    s.v = 1'b0;
    step(s, "reset", 0, 0, 0, 0);
    step(s, "reset_hold", 0, 0, 0, 0);

    // ALU -> branch, ready after execute
    step(ins(1, 1, 2, 1, 8, 1), "alu_r8", 0, 0, 0, 0);
    s = ins(8, 0, 9, 0, -1, 0);
    step(s, "beq_stall", 1, 1, 0, 0);
    step(s, "beq_go", 0, 2, 0, 0);
    step(s, "r8_e2", 0, 3, 0, 0);
    step(s, "r8_retired", 0, 0, 0, 0);

    // load-use
    step(ins(0, 3, 0, 3, 9, 2), "lw_r9", 0, 0, 0, 0);
    s = ins(1, 1, 9, 1, 11, 1);
    step(s, "add_stall", 1, 0, 1, 0);
    step(s, "add_go", 0, 0, 2, 0);
    step(ins(0, 3, 0, 3, 9, 2), "lw_r9b", 0, 0, 0, 0);
    step(ins(0, 3, 0, 3, 12, 1), "gap_r12", 0, 0, 0, 0);
    step(ins(12, 1, 9, 1, -1, 0), "add_gap", 0, 1, 2, 0);

    // youngest match, r0
    step(ins(0, 3, 0, 3, 10, 1), "r10_a", 0, 0, 0, 0);
    step(ins(0, 3, 0, 3, 10, 1), "r10_b", 0, 0, 0, 0);
    step(ins(10, 1, 0, 0, 0, 2), "r10_young", 0, 1, 0, 0);
    step(ins(0, 0, 10, 1, -1, 0), "r0_read", 0, 0, 2, 0);
    step(ins(10, 0, 0, 3, -1, 0), "r10_e2", 0, 3, 0, 0);

    // immediate-ready write never hazards
    step(ins(0, 3, 0, 3, 14, 0), "jal_r14", 0, 0, 0, 0);
    step(ins(14, 0, 0, 3, -1, 0), "r14_imm", 0, 1, 0, 0);

    // invalid decode: no stall, no entry
    step(ins(0, 3, 0, 3, 15, 2), "lw_r15", 0, 0, 0, 0);
    s = ins(15, 0, 0, 3, 15, 2);
    s.v = 1'b0;
    step(s, "invalid", 0, 1, 0, 0);
    s = ins(15, 0, 0, 3, -1, 0);
    step(s, "r15_e1_hz", 1, 2, 0, 0);
    step(s, "r15_e2", 0, 3, 0, 0);

    // freeze with load in E and MUL running
    s = ins(0, 3, 0, 3, 16, 2);
    s.mu = 1'b1;
    s.ms = 1'b1;
    step(s, "lw_mul", 0, 0, 0, 0);
    s = ins(0, 3, 16, 1, -1, 0);
    s.mu = 1'b1;
    s.frz = 1'b1;
    for (int i = 0; i < 3; i++)
      step(s, "frozen", 1, 0, 1, m);
    s.frz = 1'b0;
    step(s, "thaw", 1, 0, 1, m);
    step(s, "mul_tail", m, 0, 2, m);
    step(s, "mul_done", 0, 0, 3, 0);

    // divide then mflo
    s = ins(0, 3, 0, 3, -1, 0);
    s.mu = 1'b1;
    s.ms = 1'b1;
    s.md = 1'b1;
    step(s, "div_start", 0, 0, 0, 0);
    s = ins(0, 3, 0, 3, -1, 0);
    s.mu = 1'b1;
    for (int i = 0; i < 10; i++)
      step(s, "mflo_wait", m, 0, 0, m);
    step(s, "mflo_go", 0, 0, 0, 0);

    // start while busy must not reload
    s = ins(0, 3, 0, 3, -1, 0);
    s.mu = 1'b1;
    s.ms = 1'b1;
    step(s, "mul_start", 0, 0, 0, 0);
    s.md = 1'b1;
    for (int i = 0; i < 5; i++)
      step(s, "div_blocked", m, 0, 0, m);
    step(s, "div_go", 0, 0, 0, 0);
    step(ins(0, 3, 0, 3, -1, 0), "div_run", 0, 0, 0, m);
    step(ins(0, 3, 0, 3, 18, 2), "lw_r18", 0, 0, 0, m);

    // async reset mid-divide with pending load
    s = ins(0, 3, 18, 1, -1, 0);
    s.mu = 1'b1;
    s.rst_n = 1'b0;
    step(s, "rst_async", 0, 0, 0, 0);
    s.rst_n = 1'b1;
    step(s, "rst_release", 0, 0, 0, 0);
    step(ins(0, 3, 0, 3, 19, 1), "post_r19", 0, 0, 0, 0);
    s = ins(19, 0, 0, 3, -1, 0);
    step(s, "post_stall", 1, 1, 0, 0);
    step(s, "post_go", 0, 2, 0, 0);

    repeat (3) @(negedge clock);
    #5;
    chk("drain", "queue", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
